// File: rtl/result_bus_arbiter.sv
// ============================================================================
// result_bus_arbiter : round-robin owner arbiter for a shared 3:1 result bus
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module result_bus_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CW       = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    req,
  input  logic [2:0]    done,
  output logic [2:0]    grant,
  output logic [1:0]    sel,
  output logic          busy,
  output logic          timeout,
  output logic [CW-1:0] owner_cycles
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t        state, nx_state;
  logic [1:0]    last, nx_last;
  logic [1:0]    nx_sel;
  logic [2:0]    nx_grant;
  logic          nx_timeout;
  logic [CW-1:0] nx_cycles;
  logic [1:0]    rst_sync;
  logic          arb_en;
  logic [1:0]    winner;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Search order last+1, last+2, last so the previous owner has lowest priority.
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] l);
    logic [1:0] c1, c2;
    c1 = inc3(l);
    c2 = inc3(c1);
    if (r[c1])      return c1;
    else if (r[c2]) return c2;
    else            return l;
  endfunction

  // Reset release is resynchronised so arbitration starts on a clean edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign arb_en = rst_sync[1];
  assign winner = pick(req, last);

  always_comb begin
    nx_state   = state;
    nx_last    = last;
    nx_sel     = sel;
    nx_grant   = grant;
    nx_timeout = 1'b0;
    nx_cycles  = owner_cycles;
    case (state)
      S_IDLE: begin
        if (arb_en && (req != 3'b000)) begin
          nx_state  = S_OWN;
          nx_grant  = 3'b001 << winner;
          nx_sel    = winner;
          nx_last   = winner;
          nx_cycles = CW'(1);
        end
      end
      S_OWN: begin
        if (done[sel] || !req[sel]) begin
          nx_state  = S_TURN;
          nx_grant  = 3'b000;
          nx_cycles = '0;
        end else if (owner_cycles == CW'(MAX_HOLD)) begin
          nx_state   = S_TURN;
          nx_grant   = 3'b000;
          nx_cycles  = '0;
          nx_timeout = 1'b1;
        end else begin
          nx_cycles = owner_cycles + CW'(1);
        end
      end
      S_TURN: begin
        nx_state = S_IDLE;
        nx_grant = 3'b000;
      end
      default: begin
        nx_state  = S_IDLE;
        nx_grant  = 3'b000;
        nx_cycles = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      last         <= 2'd2;
      sel          <= 2'd0;
      grant        <= 3'b000;
      timeout      <= 1'b0;
      owner_cycles <= '0;
    end else begin
      state        <= nx_state;
      last         <= nx_last;
      sel          <= nx_sel;
      grant        <= nx_grant;
      timeout      <= nx_timeout;
      owner_cycles <= nx_cycles;
    end
  end

  assign busy = |grant;

endmodule

`default_nettype wire

// File: tb/tb_result_bus_arbiter.sv
// ============================================================================
// tb_result_bus_arbiter : directed bench with a cycle model of the arbiter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_bus_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int CW       = $clog2(MAX_HOLD + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [2:0]    req = 3'b000;
  logic [2:0]    done = 3'b000;
  logic [2:0]    grant;
  logic [1:0]    sel;
  logic          busy;
  logic          timeout;
  logic [CW-1:0] owner_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  result_bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .done         (done),
    .grant        (grant),
    .sel          (sel),
    .busy         (busy),
    .timeout      (timeout),
    .owner_cycles (owner_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner index (-1 = none), hold count, dead cycles left before
  // arbitration may resume, and edges seen since reset release.
  int m_owner, m_cyc, m_gap, m_edges, m_last, m_sel, m_to;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_cyc = 0; m_gap = 0; m_edges = 0;
      m_last = 2; m_sel = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_gap > 0) begin
        m_gap--;
      end else if (m_owner >= 0) begin
        if (done[m_owner] || !req[m_owner]) begin
          m_owner = -1; m_cyc = 0; m_gap = 1;
        end else if (m_cyc == MAX_HOLD) begin
          m_owner = -1; m_cyc = 0; m_gap = 1; m_to = 1;
        end else begin
          m_cyc++;
        end
      end else if (m_edges >= 2 && req != 3'b000) begin
        for (int i = 1; i <= 3; i++) begin
          int c;
          c = (m_last + i) % 3;
          if (m_owner < 0 && req[c]) m_owner = c;
        end
        m_last = m_owner; m_sel = m_owner; m_cyc = 1;
      end
      if (m_edges < 2) m_edges++;
    end
  end

  always @(negedge clk) begin
    if ($time > 1) begin
      chk("grant",        int'(grant),        (m_owner >= 0) ? (1 << m_owner) : 0);
      chk("sel",          int'(sel),          m_sel);
      chk("busy",         int'(busy),         (m_owner >= 0) ? 1 : 0);
      chk("timeout",      int'(timeout),      m_to);
      chk("owner_cycles", int'(owner_cycles), m_cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(output logic [2:0] g);
    int k;
    k = 0;
    while (grant == 3'b000 && k < 20) begin
      step(1);
      k++;
    end
    if (k >= 20) chk("grant_wait_timeout", 1, 0);
    g = grant;
  endtask

  logic [2:0] g;
  logic [2:0] fair_exp [4];

  initial begin
    fair_exp[0] = 3'b100; fair_exp[1] = 3'b001;
    fair_exp[2] = 3'b010; fair_exp[3] = 3'b100;

    // Reset then single request
    #1 rst_n = 1'b0;
    #20;
    chk("rst_grant", int'(grant), 0);
    chk("rst_sel",   int'(sel),   0);
    @(negedge clk); #1 rst_n = 1'b1;
    step(2);
    req = 3'b010;
    step(1);
    chk("single_grant", int'(grant), 3'b010);
    chk("single_sel",   int'(sel),   1);
    chk("single_busy",  int'(busy),  1);
    done = 3'b010;
    step(1);
    chk("single_release", int'(grant), 0);
    chk("single_to",      int'(timeout), 0);
    done = 3'b000; req = 3'b000;
    step(3);

    // Round-robin fairness, pointer starts after owner 1
    req = 3'b111;
    for (int n = 0; n < 4; n++) begin
      wait_grant(g);
      chk("fair_order", int'(g), int'(fair_exp[n]));
      step(2);
      done = grant;
      step(1);
      done = 3'b000;
    end
    req = 3'b000;
    step(4);

    // Watchdog
    req = 3'b001;
    wait_grant(g);
    for (int c = 1; c <= MAX_HOLD; c++) begin
      chk("wd_cycles", int'(owner_cycles), c);
      chk("wd_grant",  int'(grant), 3'b001);
      if (c < MAX_HOLD) step(1);
    end
    step(1);
    chk("wd_timeout", int'(timeout), 1);
    chk("wd_release", int'(grant), 0);
    step(1);
    chk("wd_timeout_clear", int'(timeout), 0);
    step(1);
    chk("wd_regrant", int'(grant), 3'b001);

    // Non-owner done ignored; done on the watchdog edge is a normal release
    done = 3'b100;
    step(1);
    chk("ignore_done", int'(grant), 3'b001);
    done = 3'b000;
    step(2);
    chk("sim_cycles", int'(owner_cycles), MAX_HOLD);
    done = 3'b001;
    step(1);
    chk("sim_release", int'(grant), 0);
    chk("sim_no_to",   int'(timeout), 0);
    done = 3'b000; req = 3'b000;
    step(3);

    // Owner 2 drops request, pointer wraps to 0
    req = 3'b100;
    wait_grant(g);
    chk("wrap_owner2", int'(sel), 2);
    req = 3'b011;
    step(3);
    chk("wrap_grant", int'(grant), 3'b001);
    chk("wrap_sel",   int'(sel),   0);
    req = 3'b000;
    step(3);

    // Asynchronous reset mid-grant
    req = 3'b100;
    wait_grant(g);
    chk("mid_owner", int'(g), 3'b100);
    rst_n = 1'b0;
    #1;
    chk("async_grant", int'(grant), 0);
    chk("async_sel",   int'(sel),   0);
    chk("async_busy",  int'(busy),  0);
    req = 3'b000;
    @(negedge clk); #1 rst_n = 1'b1;
    step(2);
    req = 3'b110;
    step(1);
    chk("post_rst_grant", int'(grant), 3'b010);
    req = 3'b000;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/result_bus_arbiter.md
Name: result_bus_arbiter

Overview:
- Round-robin arbiter for one shared 3-input result bus.
- Up to three requesters compete for the bus.
- Drives the 2-bit select of the downstream 3:1 mux: 00 selects d0, 01 selects d1, 10 selects d2.
- Grants one owner at a time, holds the grant until the owner finishes, and uses a watchdog to force release from a stuck owner.

Parameters:
- MAX_HOLD, 16: maximum cycles one owner may hold the bus before forced release. Legal range 2..255.
- CW, $clog2(MAX_HOLD+1): hold counter width. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  3  request per requester; bit i = requester i.
- done  input  3  per-requester release strobe; honoured only for the current owner.
- grant  output  3  one-hot grant, registered; 000 when the bus is free.
- sel  output  2  mux select, registered; 00/01/10 for requester 0/1/2. 11 is never driven.
- busy  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse on forced release.
- owner_cycles  output  CW  cycles the current owner has held the bus; 0 when idle.

Behaviour:
Reset (async, rst_n low):
- grant=000, sel=00, busy=0, timeout=0, owner_cycles=0, state=IDLE.
- Round-robin pointer last=2, so requester 0 has top priority first.
- Reset asserted mid-grant drops the grant immediately, with no timeout pulse.
- Deassertion is synchronised internally by a 2-flop release; the first arbitration happens no earlier than the 2nd rising edge after rst_n rises.

States: IDLE, OWN, TURN.

IDLE:
- If req != 000 at a rising edge, pick the first set bit searching last+1, last+2, last (mod 3).
- On that edge: grant=onehot(winner), sel=winner, busy=1, owner_cycles=1, last=winner, go to OWN.
- Request-to-grant latency is 1 cycle.
- Otherwise hold IDLE. sel keeps its previous value; it is not cleared, to avoid mux glitches.

OWN (owner k):
- Normal release: if done[k]=1 or req[k]=0 at an edge, go to TURN. grant=000, busy=0, owner_cycles=0, timeout=0.
- Forced release: else if owner_cycles==MAX_HOLD, go to TURN with the same outputs but timeout=1 for that one cycle.
- Otherwise owner_cycles increments (saturating at MAX_HOLD); grant and sel are stable.
- done/req of non-owners are ignored while in OWN.
- done[k] and the watchdog limit on the same edge: treat as normal release, timeout=0.

TURN:
- Exactly one dead cycle; grant=000. Bus turnaround guarantees no two-owner overlap.
- Next edge: go to IDLE, and IDLE arbitration applies on the following edge.
- Consequence: back-to-back owners are separated by a minimum gap of 2 cycles with grant=000.
- timeout returns to 0 here.

Arithmetic and invariants:
- Pointer arithmetic is mod 3; 2+1 wraps to 0.
- grant is always 000 or one-hot.
- sel==index(grant) whenever busy=1.
- busy==|grant.
- done pulses outside OWN are ignored and do not persist.

Test Plan:
- Reset then single request: rst_n low, then high; wait 2 edges; req=010 -> next edge grant=010, sel=01, busy=1; done=010 for 1 cycle -> next edge grant=000, busy=0, timeout=0.
- Round-robin fairness: req=111 held, each owner pulses done after 3 cycles -> grant order 001, 010, 100, 001 with sel 00, 01, 10, 00; 2 grant=000 cycles between owners; never two bits set.
- Watchdog: MAX_HOLD=4, req=001 held, done=000 -> grant=001 for exactly 4 cycles with owner_cycles 1..4; then grant=000 and timeout=1 for one cycle; next grant goes to 001 again only if it is the only requester.
- Simultaneous events: MAX_HOLD=4, done[owner] on the same edge owner_cycles==4 -> release with timeout=0. done=100 while owner is 001 -> ignored, grant stays 001.
- Request drop and wrap: owner 2 (sel=10) drops req, req=011 pending -> after turnaround grant=001 (pointer wraps 2->0), sel=00.
- Reset mid-operation: rst_n low while grant=100, async -> grant=000, sel=00, busy=0 without waiting for clk. After release, req=110 -> grant=010 (pointer reset to 2).
